// File: rtl/stateless_writeback_stage.sv
// Writeback stage behind the stateless ALU atom: merges the ALU result into one PHV field
// and buffers the merged PHV in a 2-entry skid FIFO with valid/ready on both sides.
module stateless_writeback_stage #(
    parameter int COUNT_WIDTH = 32,
    parameter int NUM_FIELDS  = 4,
    parameter int DST_W       = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_FIELDS*COUNT_WIDTH-1:0] in_phv,
    input  logic [COUNT_WIDTH-1:0]            in_result,
    input  logic                              in_wr_en,
    input  logic [DST_W-1:0]                  in_dst,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_FIELDS*COUNT_WIDTH-1:0] out_phv,
    output logic [COUNT_WIDTH-1:0]            pkt_count,
    output logic                              dst_err
);

    localparam int PHV_W = NUM_FIELDS * COUNT_WIDTH;
    localparam logic [DST_W:0] FIELD_LIMIT = (DST_W + 1)'(NUM_FIELDS);

    logic [PHV_W-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [1:0]       count_next;
    logic             push;
    logic             pop;
    logic             dst_in_range;
    logic [PHV_W-1:0] merged;

    assign push         = in_valid & in_ready;
    assign pop          = out_valid & out_ready;
    assign dst_in_range = ({1'b0, in_dst} < FIELD_LIMIT);
    assign out_phv      = mem[rd_ptr];

    // An out-of-range destination leaves the PHV untouched; only dst_err reports it.
    always_comb begin
        merged = in_phv;
        if (in_wr_en && dst_in_range) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                if (in_dst == DST_W'(i)) begin
                    merged[i*COUNT_WIDTH +: COUNT_WIDTH] = in_result;
                end
            end
        end
    end

    always_comb begin
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // Flags are derived from count_next so they stay registered yet track occupancy exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            pkt_count <= '0;
            dst_err   <= 1'b0;
            mem[0]    <= '0;
            mem[1]    <= '0;
        end else begin
            count     <= count_next;
            in_ready  <= (count_next != 2'd2);
            out_valid <= (count_next != 2'd0);
            dst_err   <= push & in_wr_en & ~dst_in_range;
            if (push) begin
                mem[wr_ptr] <= merged;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr    <= ~rd_ptr;
                pkt_count <= pkt_count + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_stateless_writeback_stage.sv
// Self-checking bench for stateless_writeback_stage: directed vector table, hand-written
// backpressure/reset sequences and randomized traffic against a queue-based reference model.
module tb_stateless_writeback_stage;

    localparam int CW = 32;
    localparam int NF = 4;
    localparam int DW = 3;
    localparam int PW = NF * CW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_phv;
    logic [CW-1:0] in_result;
    logic          in_wr_en;
    logic [DW-1:0] in_dst;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_phv;
    logic [CW-1:0] pkt_count;
    logic          dst_err;

    logic          w_in_valid;
    logic          w_in_ready;
    logic [15:0]   w_in_phv;
    logic [3:0]    w_in_result;
    logic          w_in_wr_en;
    logic [2:0]    w_in_dst;
    logic          w_out_valid;
    logic          w_out_ready;
    logic [15:0]   w_out_phv;
    logic [3:0]    w_pkt_count;
    logic          w_dst_err;

    stateless_writeback_stage #(.COUNT_WIDTH(CW), .NUM_FIELDS(NF), .DST_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_phv(in_phv), .in_result(in_result),
        .in_wr_en(in_wr_en), .in_dst(in_dst),
        .out_valid(out_valid), .out_ready(out_ready), .out_phv(out_phv),
        .pkt_count(pkt_count), .dst_err(dst_err)
    );

    // Narrow instance so the packet counter wrap is reachable in a few dozen cycles.
    stateless_writeback_stage #(.COUNT_WIDTH(4), .NUM_FIELDS(4), .DST_W(3)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_phv(w_in_phv), .in_result(w_in_result),
        .in_wr_en(w_in_wr_en), .in_dst(w_in_dst),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_phv(w_out_phv),
        .pkt_count(w_pkt_count), .dst_err(w_dst_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] phv;
        logic [CW-1:0] res;
        logic          wr;
        logic [DW-1:0] dst;
        logic [PW-1:0] expPhv;
        logic          expErr;
    } vec_t;

    vec_t          vecs [8];
    logic [PW-1:0] mq [$];
    logic [CW-1:0] mpkt;
    logic          merr;
    logic          lastPush;
    int            errors = 0;
    int            checks = 0;

    function automatic logic [PW-1:0] refMerge(input logic [PW-1:0] phv, input logic [CW-1:0] res,
                                               input logic wr, input logic [DW-1:0] dst);
        logic [PW-1:0] r;
        r = phv;
        if (wr && int'(dst) < NF) r[int'(dst)*CW +: CW] = res;
        return r;
    endfunction

    function automatic logic [PW-1:0] tagPhv(input logic [CW-1:0] tag);
        return {32'h0, 32'h0, 32'h0, tag};
    endfunction

    task automatic checkVal(input string name, input logic [PW-1:0] actual, input logic [PW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [PW-1:0] phv, input logic [CW-1:0] res,
                                 input logic wr, input logic [DW-1:0] dst, input logic ordy);
        in_valid  = v;
        in_phv    = phv;
        in_result = res;
        in_wr_en  = wr;
        in_dst    = dst;
        out_ready = ordy;
    endtask

    task automatic checkOutput();
        checkVal("in_ready", in_ready, (mq.size() < 2));
        checkVal("out_valid", out_valid, (mq.size() > 0));
        if (mq.size() > 0) checkVal("out_phv", out_phv, mq[0]);
        checkVal("pkt_count", pkt_count, mpkt);
        checkVal("dst_err", dst_err, merr);
    endtask

    // Model decides push/pop from its own occupancy, then advances with the clock edge.
    task automatic stepCycle();
        logic          push;
        logic          pop;
        logic [PW-1:0] m;
        push = in_valid && (mq.size() < 2);
        pop  = out_ready && (mq.size() > 0);
        m    = refMerge(in_phv, in_result, in_wr_en, in_dst);
        @(posedge clk);
        if (pop) begin
            void'(mq.pop_front());
            mpkt = mpkt + 1;
        end
        if (push) mq.push_back(m);
        merr     = push && in_wr_en && (int'(in_dst) >= NF);
        lastPush = push;
        #1;
        checkOutput();
    endtask

    initial begin
        logic [PW-1:0] base;
        logic [3:0]    wcnt;
        int            wsize;
        logic          wpush;
        logic          wpop;

        base = 128'h00000004_00000003_00000002_00000001;
        vecs[0] = '{base, 32'hAA, 1'b1, 3'd2, 128'h00000004_000000AA_00000002_00000001, 1'b0};
        vecs[1] = '{base, 32'hFF, 1'b0, 3'd1, base, 1'b0};
        vecs[2] = '{base, 32'h55, 1'b1, 3'd5, base, 1'b1};
        vecs[3] = '{base, 32'hDEADBEEF, 1'b1, 3'd0, 128'h00000004_00000003_00000002_DEADBEEF, 1'b0};
        vecs[4] = '{base, 32'h12345678, 1'b1, 3'd3, 128'h12345678_00000003_00000002_00000001, 1'b0};
        vecs[5] = '{base, 32'h77, 1'b1, 3'd4, base, 1'b1};
        vecs[6] = '{base, 32'h66, 1'b1, 3'd7, base, 1'b1};
        vecs[7] = '{base, 32'h99, 1'b0, 3'd7, base, 1'b0};

        rst_n = 1'b0;
        applyStimulus(0, '0, '0, 0, '0, 0);
        w_in_valid = 0; w_in_phv = '0; w_in_result = '0; w_in_wr_en = 0; w_in_dst = '0; w_out_ready = 0;
        mpkt = '0; merr = 0; lastPush = 0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst_in_ready", in_ready, 1);
        checkVal("rst_out_valid", out_valid, 0);
        checkVal("rst_out_phv", out_phv, 0);
        checkVal("rst_pkt_count", pkt_count, 0);
        checkVal("rst_dst_err", dst_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stepCycle();

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, vecs[i].phv, vecs[i].res, vecs[i].wr, vecs[i].dst, 1);
            stepCycle();
            checkVal("tbl_valid", out_valid, 1);
            checkVal("tbl_phv", out_phv, vecs[i].expPhv);
            checkVal("tbl_err", dst_err, vecs[i].expErr);
            applyStimulus(0, vecs[i].phv, vecs[i].res, vecs[i].wr, vecs[i].dst, 1);
            stepCycle();
            checkVal("tbl_err_clear", dst_err, 0);
            checkVal("tbl_pkt_count", pkt_count, i + 1);
        end

        // Back-to-back illegal writes hold dst_err high continuously.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, base, 32'h1, 1, 3'd6, 1);
            stepCycle();
            checkVal("err_b2b", dst_err, 1);
        end
        applyStimulus(0, base, '0, 0, '0, 1);
        repeat (2) stepCycle();

        // Backpressure: third packet held until the first pop frees a slot.
        applyStimulus(1, tagPhv(10), '0, 0, '0, 0);
        stepCycle();
        applyStimulus(1, tagPhv(11), '0, 0, '0, 0);
        stepCycle();
        applyStimulus(1, tagPhv(12), '0, 0, '0, 0);
        stepCycle();
        checkVal("bp_full", in_ready, 0);
        stepCycle();
        checkVal("bp_held", in_ready, 0);
        out_ready = 1;
        checkVal("bp_head10", out_phv, tagPhv(10));
        stepCycle();
        checkVal("bp_refill", in_ready, 1);
        checkVal("bp_head11", out_phv, tagPhv(11));
        stepCycle();
        in_valid = 0;
        checkVal("bp_head12", out_phv, tagPhv(12));
        stepCycle();
        checkVal("bp_drained", out_valid, 0);

        // Streaming: 100 packets, one per cycle, occupancy never reaches 2.
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1, {$urandom, $urandom, $urandom, $urandom}, $urandom,
                          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1);
            stepCycle();
            checkVal("stream_ready", in_ready, 1);
            checkVal("stream_valid", out_valid, 1);
        end
        applyStimulus(0, '0, '0, 0, '0, 1);
        stepCycle();
        checkVal("stream_total", pkt_count, 32'd100 + 32'd8 + 32'd3 + 32'd3);

        // Random traffic with data held stable until accepted.
        applyStimulus(0, '0, '0, 0, '0, 1);
        for (int i = 0; i < 300; i++) begin
            if (lastPush || !in_valid) begin
                applyStimulus(($urandom_range(0, 3) != 0), {$urandom, $urandom, $urandom, $urandom},
                              $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                              ($urandom_range(0, 2) != 0));
            end else begin
                out_ready = ($urandom_range(0, 2) != 0);
            end
            stepCycle();
        end

        // Counter wrap on the narrow instance.
        applyStimulus(0, '0, '0, 0, '0, 1);
        w_in_valid = 1; w_out_ready = 1;
        wcnt = '0; wsize = 0;
        for (int i = 0; i < 40; i++) begin
            wpush = w_in_valid && (wsize < 2);
            wpop  = w_out_ready && (wsize > 0);
            stepCycle();
            wsize = wsize + int'(wpush) - int'(wpop);
            if (wpop) wcnt = wcnt + 4'd1;
            checkVal("wrap_cnt", w_pkt_count, wcnt);
            checkVal("wrap_ready", w_in_ready, (wsize < 2));
            checkVal("wrap_valid", w_out_valid, (wsize > 0));
            if (wsize > 0) checkVal("wrap_phv", w_out_phv, 0);
            checkVal("wrap_err", w_dst_err, 0);
        end
        w_in_valid = 0;

        // Reset with two packets buffered: everything clears immediately, nothing stale after.
        applyStimulus(0, '0, '0, 0, '0, 1);
        repeat (3) stepCycle();
        applyStimulus(1, tagPhv(32'h21), '0, 0, '0, 0);
        stepCycle();
        applyStimulus(1, tagPhv(32'h22), '0, 0, '0, 0);
        stepCycle();
        checkVal("pre_rst_full", in_ready, 0);
        applyStimulus(0, '0, '0, 0, '0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        mq.delete();
        mpkt = '0;
        merr = 0;
        checkVal("mid_rst_valid", out_valid, 0);
        checkVal("mid_rst_ready", in_ready, 1);
        checkVal("mid_rst_phv", out_phv, 0);
        checkVal("mid_rst_cnt", pkt_count, 0);
        @(posedge clk);
        #1;
        checkVal("mid_rst_hold", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1;
        repeat (3) begin
            stepCycle();
            checkVal("post_rst_empty", out_valid, 0);
        end
        applyStimulus(1, tagPhv(32'h33), 32'h44, 1, 3'd1, 1);
        stepCycle();
        checkVal("post_rst_phv", out_phv, {32'h0, 32'h0, 32'h44, 32'h33});
        applyStimulus(0, '0, '0, 0, '0, 1);
        stepCycle();
        checkVal("post_rst_cnt", pkt_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
